dmem_mmio: RTL and testbench

Data-side memory responder for the single-cycle core: answers the CPU's data port (address = ALU output, write data, write enable, read data) with a word RAM plus a small memory-mapped I/O page. The I/O page holds an LED register, a free-running cycle counter, and an 8-bit character FIFO drained by an external consumer over a valid/ready handshake. It sits between the core's data port and the board and testbench.

---
 rtl/dmem_mmio.sv | 118 +++++++++++
 tb/tb_dmem_mmio.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory responder: word RAM plus an MMIO page holding an LED register,
// a free-running cycle counter and a character FIFO drained over valid/ready.
module dmem_mmio #(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_LED    = 2'd0,
    REG_CYCLE  = 2'd1,
    REG_TXDATA = 2'd2,
    REG_STATUS = 2'd3
  } io_reg_e;

  logic [31:0]       ram_q [2**RAM_AW];
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              is_ram, is_io;
  io_reg_e           io_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              full, empty, push_req, push_ok, pop;
  logic              unused_addr;

  assign is_ram  = (addr[31:28] == 4'h0);
  assign is_io   = (addr[31:4] == 28'hFFFF_000);
  assign io_sel  = io_reg_e'(addr[3:2]);
  assign ram_idx = addr[RAM_AW+1:2];
  assign unused_addr = ^addr[1:0];

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign out_data  = fifo_q[rd_ptr_q];
  assign led       = led_q;

  assign pop      = out_valid & out_ready;
  assign push_req = we & is_io & (io_sel == REG_TXDATA);
  // A push into a full FIFO is accepted only if the head leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    led_d = led_q;
    if (we && is_io && io_sel == REG_LED) led_d = wdata[LED_W-1:0];

    cycle_d = cycle_q + 32'd1;
    if (we && is_io && io_sel == REG_CYCLE) cycle_d = wdata;

    ovf_d = ovf_q;
    if (we && is_io && io_sel == REG_STATUS) ovf_d = 1'b0;
    if (push_req && full && !pop)            ovf_d = 1'b1;

    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (we && is_ram) ram_q[ram_idx] <= wdata;
    if (push_ok)      fifo_q[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram_q[ram_idx];
    end else if (is_io) begin
      case (io_sel)
        REG_LED:    rdata = 32'(led_q);
        REG_CYCLE:  rdata = cycle_q;
        REG_TXDATA: rdata = 32'(count_q);
        REG_STATUS: rdata = {29'b0, ovf_q, empty, full};
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, LED, cycle counter, FIFO and reset.
module tb_dmem_mmio;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_TX     = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [15:0] led;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;

  int vectors = 0;
  int miscompares = 0;

  dmem_mmio dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .led       (led),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_z [8];

    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state and counter running from 0
    check("rst_led", 32'(led), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    load_chk("rst_status", A_STATUS, 32'h2);
    load_chk("rst_count", A_TX, 32'h0);
    for (int i = 0; i < 5; i++) begin
      load_chk($sformatf("cycle_%0d", i), A_CYCLE, 32'(i));
      tick();
    end

    store(A_CYCLE, 32'hFFFF_FFFE);
    load_chk("cycle_ld0", A_CYCLE, 32'hFFFF_FFFE);
    tick();
    load_chk("cycle_ld1", A_CYCLE, 32'hFFFF_FFFF);
    tick();
    load_chk("cycle_wrap", A_CYCLE, 32'h0);

    // RAM with ignored low bits and aliasing
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    load_chk("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
    load_chk("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
    store(32'h0000_0014, 32'h0000_55AA);
    load_chk("ram_rd2", 32'h0000_0014, 32'h0000_55AA);
    load_chk("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);

    // LED and unmapped space
    store(A_LED, 32'h1234_ABCD);
    check("led_out", 32'(led), 32'h0000_ABCD);
    load_chk("led_rd", A_LED, 32'h0000_ABCD);
    store(32'hFFFF_0010, 32'hFFFF_FFFF);
    check("unmap_led", 32'(led), 32'h0000_ABCD);
    load_chk("unmap_rd", 32'hFFFF_0010, 32'h0);
    load_chk("unmap_status", A_STATUS, 32'h2);
    load_chk("unmap_count", A_TX, 32'h0);

    // FIFO fill, overflow, clear ovf, drain
    for (int i = 0; i < 8; i++) store(A_TX, 32'h41 + 32'(i));
    load_chk("fill_status", A_STATUS, 32'h1);
    load_chk("fill_count", A_TX, 32'h8);
    check("fill_valid", 32'(out_valid), 32'h1);
    check("fill_head", 32'(out_data), 32'h41);
    store(A_TX, 32'h49);
    load_chk("ovf_status", A_STATUS, 32'h5);
    load_chk("ovf_count", A_TX, 32'h8);
    check("ovf_head", 32'(out_data), 32'h41);
    store(A_STATUS, 32'h0);
    load_chk("ovf_clr", A_STATUS, 32'h1);

    addr = 32'h0000_0010;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_data), 32'h41 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'h0);
    load_chk("drain_status", A_STATUS, 32'h2);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) store(A_TX, 32'h41 + 32'(i));
    check("pp_head0", 32'(out_data), 32'h41);
    out_ready = 1'b1;
    store(A_TX, 32'h5A);
    load_chk("pp_count", A_TX, 32'h8);
    load_chk("pp_status", A_STATUS, 32'h1);
    for (int i = 0; i < 7; i++) exp_z[i] = 8'h42 + 8'(i);
    exp_z[7] = 8'h5A;
    addr = 32'h0000_0010;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(out_data), 32'(exp_z[i]));
      tick();
    end
    out_ready = 1'b0;
    check("pp_empty", 32'(out_valid), 32'h0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) store(A_TX, 32'h31 + 32'(i));
    load_chk("mid_count", A_TX, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_led", 32'(led), 32'h0);
    load_chk("mrst_cycle", A_CYCLE, 32'h0);
    load_chk("mrst_count", A_TX, 32'h0);
    load_chk("mrst_status", A_STATUS, 32'h2);
    load_chk("mrst_ram", 32'h0000_0010, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
